// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path and the display stage that
// decodes state_led.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_LAP     = 2'b10,
        ST_PAUSED  = 2'b11
    } state_e;

    localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low push-button: 2-flop synchroniser, stability
// debounce and a registered one-cycle pulse on each debounced press.
module key_debounce #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_vld;
    logic             r_armed;
    logic             r_press;

    // r_vld marks when r_sync2 holds a real sample rather than its reset value.
    // r_armed blocks the press of a key that was already held through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_db      <= 1'b1;
            r_db_prev <= 1'b1;
            r_cnt     <= '0;
            r_vld     <= 2'b00;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_vld     <= {r_vld[0], 1'b1};
            r_db_prev <= r_db;
            r_press   <= r_armed & r_db_prev & ~r_db;
            if (r_vld[1] && r_sync2 && r_db) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_control_fsm.sv
// Stopwatch mode controller: debounces the three buttons and drives the counter
// enable, its synchronous clear and the lap display-hold flag.
module stopwatch_control_fsm
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_reset_n,
    input  logic       key_lap_n,
    input  logic       at_max,
    output logic       enable,
    output logic       reset_counter,
    output logic       display_hold,
    output logic [1:0] state_led
);

    logic   w_start;
    logic   w_reset;
    logic   w_lap;
    state_e r_state;
    state_e w_state_nxt;
    logic   r_enable;
    logic   r_hold;
    logic   r_rc;
    logic   w_rc_nxt;

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_db_start (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_start_n),
        .o_press (w_start)
    );

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_db_reset (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_reset_n),
        .o_press (w_reset)
    );

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_db_lap (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_lap_n),
        .o_press (w_lap)
    );

    // Each branch is an if/else chain so only the highest-priority valid event acts.
    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_reset) begin
                    w_rc_nxt = 1'b1;
                end else if (w_start) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING, ST_LAP: begin
                if (at_max || w_start) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_lap) begin
                    w_state_nxt = (r_state == ST_RUNNING) ? ST_LAP : ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                if (w_reset) begin
                    w_state_nxt = ST_IDLE;
                    w_rc_nxt    = 1'b1;
                end else if (w_start && !at_max) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_hold   <= 1'b0;
            r_rc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_enable <= (w_state_nxt == ST_RUNNING) || (w_state_nxt == ST_LAP);
            r_hold   <= (w_state_nxt == ST_LAP);
            r_rc     <= w_rc_nxt;
        end
    end

    assign enable        = r_enable;
    assign display_hold  = r_hold;
    assign reset_counter = r_rc;
    assign state_led     = r_state;

endmodule

// File: tb/tb_stopwatch_control_fsm.sv
// Directed bench for stopwatch_control_fsm with a short debounce window.
module tb_stopwatch_control_fsm;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_start_n;
    logic       key_reset_n;
    logic       key_lap_n;
    logic       at_max;
    logic       enable;
    logic       reset_counter;
    logic       display_hold;
    logic [1:0] state_led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_control_fsm #(.DEBOUNCE_MS(DB), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_start_n   (key_start_n),
        .key_reset_n   (key_reset_n),
        .key_lap_n     (key_lap_n),
        .at_max        (at_max),
        .enable        (enable),
        .reset_counter (reset_counter),
        .display_hold  (display_hold),
        .state_led     (state_led)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presses the selected keys together, then releases; counts output activity.
    task automatic press(input logic s, input logic r, input logic l, input int hold,
                         input int settle, output int rc_cnt, output int en_cnt);
        rc_cnt = 0;
        en_cnt = 0;
        key_start_n = ~s;
        key_reset_n = ~r;
        key_lap_n   = ~l;
        repeat (hold) begin
            step(1);
            rc_cnt += int'(reset_counter);
            en_cnt += int'(enable);
        end
        key_start_n = 1'b1;
        key_reset_n = 1'b1;
        key_lap_n   = 1'b1;
        repeat (settle) begin
            step(1);
            rc_cnt += int'(reset_counter);
            en_cnt += int'(enable);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key_start_n = 1'b1;
        key_reset_n = 1'b1;
        key_lap_n = 1'b1;
        at_max = 1'b0;
        #2;
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
        checks++; if (reset_counter !== 1'b0) begin errors++; $display("FAIL reset_rc: got %b expected 0", reset_counter); end
        checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", display_hold); end
        checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL reset_led: got %b expected 00", state_led); end
        step(3);
        rst = 1'b0;
        step(10);
    endtask

    task automatic test_start_latency;
        logic exp_en;
        key_start_n = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            step(1);
            exp_en = (i == 7);
            checks++;
            if (enable !== exp_en) begin
                errors++;
                $display("FAIL start_latency edge E+%0d: enable got %b expected %b", i, enable, exp_en);
            end
        end
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL start_led: got %b expected 01", state_led); end
        step(52);
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL start_held_led: got %b expected 01", state_led); end
        key_start_n = 1'b1;
        step(12);
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL start_release_led: got %b expected 01", state_led); end
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL start_release_enable: got %b expected 1", enable); end
    endtask

    task automatic test_bounce;
        int pat[10] = '{3, 1, 2, 2, 1, 3, 3, 1, 3, 1};
        for (int i = 0; i < 10; i++) begin
            key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(pat[i]);
        end
        key_start_n = 1'b1;
        step(12);
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL bounce_led: got %b expected 01", state_led); end
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL bounce_enable: got %b expected 1", enable); end
    endtask

    task automatic test_lap;
        int rc;
        int en;
        press(1'b0, 1'b0, 1'b1, 10, 10, rc, en);
        checks++; if (display_hold !== 1'b1) begin errors++; $display("FAIL lap1_hold: got %b expected 1", display_hold); end
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL lap1_enable: got %b expected 1", enable); end
        checks++; if (state_led !== 2'b10) begin errors++; $display("FAIL lap1_led: got %b expected 10", state_led); end
        checks++; if (rc !== 0) begin errors++; $display("FAIL lap1_rc: got %0d pulses expected 0", rc); end
        press(1'b0, 1'b0, 1'b1, 10, 10, rc, en);
        checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL lap2_hold: got %b expected 0", display_hold); end
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL lap2_led: got %b expected 01", state_led); end
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL lap2_enable: got %b expected 1", enable); end
    endtask

    task automatic test_at_max_pause;
        int rc;
        int en;
        at_max = 1'b1;
        step(1);
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL atmax_enable: got %b expected 0", enable); end
        checks++; if (state_led !== 2'b11) begin errors++; $display("FAIL atmax_led: got %b expected 11", state_led); end
        press(1'b1, 1'b0, 1'b0, 10, 10, rc, en);
        checks++; if (state_led !== 2'b11) begin errors++; $display("FAIL atmax_start_led: got %b expected 11", state_led); end
        checks++; if (en !== 0) begin errors++; $display("FAIL atmax_start_enable: got %0d cycles expected 0", en); end
        press(1'b0, 1'b1, 1'b0, 10, 10, rc, en);
        checks++; if (rc !== 1) begin errors++; $display("FAIL atmax_reset_rc: got %0d pulses expected 1", rc); end
        checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL atmax_reset_led: got %b expected 00", state_led); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL atmax_reset_enable: got %b expected 0", enable); end
        at_max = 1'b0;
        step(2);
    endtask

    task automatic test_coincident;
        int rc;
        int en;
        press(1'b1, 1'b0, 1'b0, 10, 10, rc, en);
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL coin_run_led: got %b expected 01", state_led); end
        press(1'b1, 1'b0, 1'b0, 10, 10, rc, en);
        checks++; if (state_led !== 2'b11) begin errors++; $display("FAIL coin_pause_led: got %b expected 11", state_led); end
        press(1'b1, 1'b1, 1'b0, 10, 10, rc, en);
        checks++; if (rc !== 1) begin errors++; $display("FAIL coin_rc: got %0d pulses expected 1", rc); end
        checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL coin_led: got %b expected 00", state_led); end
        checks++; if (en !== 0) begin errors++; $display("FAIL coin_enable: got %0d cycles expected 0", en); end
    endtask

    task automatic test_reset_mid;
        int rc;
        int en;
        press(1'b1, 1'b0, 1'b0, 10, 10, rc, en);
        press(1'b0, 1'b0, 1'b1, 10, 10, rc, en);
        checks++; if (state_led !== 2'b10) begin errors++; $display("FAIL mid_pre_led: got %b expected 10", state_led); end
        key_start_n = 1'b0;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL mid_enable: got %b expected 0", enable); end
        checks++; if (display_hold !== 1'b0) begin errors++; $display("FAIL mid_hold: got %b expected 0", display_hold); end
        checks++; if (reset_counter !== 1'b0) begin errors++; $display("FAIL mid_rc: got %b expected 0", reset_counter); end
        checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL mid_led: got %b expected 00", state_led); end
        step(2);
        rst = 1'b0;
        step(30);
        checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL held_through_reset_led: got %b expected 00", state_led); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL held_through_reset_enable: got %b expected 0", enable); end
        key_start_n = 1'b1;
        step(12);
        press(1'b1, 1'b0, 1'b0, 10, 10, rc, en);
        checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL repress_led: got %b expected 01", state_led); end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_bounce();
        test_lap();
        test_at_max_pause();
        test_coincident();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
